// File: rtl/stitch_tcdm_responder.sv
// rtl/stitch_tcdm_responder.sv - memory-side TCDM endpoint driving one fixed-latency SRAM bank
// Optional request/stall performance counters: define STITCH_TCDM_RESPONDER_PERF_EN.
module stitch_tcdm_responder #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned SramAddrWidth = 10,
    parameter int unsigned SramLatency   = 1,
    parameter bit          RegisterRsp   = 1'b0,
    localparam int unsigned StrbWidth    = DataWidth / 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [AddrWidth-1:0]     req_q_addr_i,
    input  logic                     req_q_write_i,
    input  logic [DataWidth-1:0]     req_q_data_i,
    input  logic [StrbWidth-1:0]     req_q_strb_i,
    input  logic                     req_q_valid_i,
    output logic [DataWidth-1:0]     rsp_p_data_o,
    output logic                     rsp_p_valid_o,
    output logic                     rsp_q_ready_o,
    output logic                     sram_req_o,
    input  logic                     sram_gnt_i,
    output logic                     sram_we_o,
    output logic [SramAddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0]     sram_wdata_o,
    output logic [StrbWidth-1:0]     sram_be_o,
    input  logic [DataWidth-1:0]     sram_rdata_i
`ifdef STITCH_TCDM_RESPONDER_PERF_EN
    ,
    input  logic                     perf_clr_i,
    output logic [31:0]              perf_acc_o,
    output logic [31:0]              perf_stall_o
`endif
);

    localparam int unsigned OffWidth = $clog2(StrbWidth);

    logic                   accept;
    logic [SramLatency-1:0] pipe_valid;
    logic [SramLatency-1:0] pipe_write;
    logic [SramLatency-1:0] valid_next;
    logic [SramLatency-1:0] write_next;
    logic                   issue_valid;
    logic [DataWidth-1:0]   issue_data;
    logic                   unused_addr;

    assign sram_req_o    = req_q_valid_i;
    assign sram_we_o     = req_q_write_i;
    assign sram_addr_o   = req_q_addr_i[OffWidth +: SramAddrWidth];
    assign sram_wdata_o  = req_q_data_i;
    assign sram_be_o     = req_q_strb_i;
    assign rsp_q_ready_o = sram_gnt_i;
    assign accept        = req_q_valid_i & sram_gnt_i;

    // Byte offset and bits above the bank window never reach the SRAM.
    assign unused_addr = ^{req_q_addr_i[AddrWidth-1:OffWidth+SramAddrWidth],
                           req_q_addr_i[OffWidth-1:0]};

    if (SramLatency > 1) begin : g_deep
        assign valid_next = {pipe_valid[SramLatency-2:0], accept};
        assign write_next = {pipe_write[SramLatency-2:0], accept & req_q_write_i};
    end else begin : g_single
        assign valid_next = accept;
        assign write_next = accept & req_q_write_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid <= '0;
            pipe_write <= '0;
        end else begin
            pipe_valid <= valid_next;
            pipe_write <= write_next;
        end
    end

    // The bank's read data lines up with the last tracking stage; writes answer with zero.
    assign issue_valid = pipe_valid[SramLatency-1];
    assign issue_data  = (issue_valid && !pipe_write[SramLatency-1]) ? sram_rdata_i : '0;

    if (RegisterRsp) begin : g_rsp_reg
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rsp_p_valid_o <= 1'b0;
                rsp_p_data_o  <= '0;
            end else begin
                rsp_p_valid_o <= issue_valid;
                rsp_p_data_o  <= issue_data;
            end
        end
    end else begin : g_rsp_comb
        assign rsp_p_valid_o = issue_valid;
        assign rsp_p_data_o  = issue_data;
    end

`ifdef STITCH_TCDM_RESPONDER_PERF_EN
    logic stall;

    assign stall = req_q_valid_i & ~sram_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_acc_o   <= '0;
            perf_stall_o <= '0;
        end else if (perf_clr_i) begin
            perf_acc_o   <= '0;
            perf_stall_o <= '0;
        end else begin
            if (accept && (perf_acc_o != 32'hFFFF_FFFF)) begin
                perf_acc_o <= perf_acc_o + 32'd1;
            end
            if (stall && (perf_stall_o != 32'hFFFF_FFFF)) begin
                perf_stall_o <= perf_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_stitch_tcdm_responder.sv
// tb/tb_stitch_tcdm_responder.sv - bench for stitch_tcdm_responder (latency 1, latency 2, registered response)
// Perf counter checks are compiled in with STITCH_TCDM_RESPONDER_PERF_EN.
module tb_stitch_tcdm_responder;

    localparam int NDUT = 3;

    typedef struct {
        int          due;
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] q_addr;
    logic        q_write;
    logic [31:0] q_data;
    logic [3:0]  q_strb;
    logic        q_valid;
    logic        gnt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] mem [1024];

    logic        p_valid [NDUT];
    logic [31:0] p_data  [NDUT];
    logic        q_ready [NDUT];
    logic        s_req   [NDUT];
    logic        s_we    [NDUT];
    logic [9:0]  s_addr  [NDUT];
    logic [31:0] s_wdata [NDUT];
    logic [3:0]  s_be    [NDUT];
`ifdef STITCH_TCDM_RESPONDER_PERF_EN
    logic        perf_clr;
    logic [31:0] perf_acc   [NDUT];
    logic [31:0] perf_stall [NDUT];
    logic [31:0] m_acc;
    logic [31:0] m_stall;
`endif

    exp_t        exp_q [NDUT][$];
    logic [31:0] shadow [1024];
    logic [31:0] last_rd [NDUT];
    int          cyc;
    int          n_assert;
    int          n_fail;
    logic        idle_zero;

    // Instance 0: latency 1; instance 1: latency 2; instance 2: latency 1 with registered response.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        stitch_tcdm_responder #(
            .SramLatency ((g == 1) ? 2 : 1),
            .RegisterRsp (g == 2)
        ) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .req_q_addr_i  (q_addr),
            .req_q_write_i (q_write),
            .req_q_data_i  (q_data),
            .req_q_strb_i  (q_strb),
            .req_q_valid_i (q_valid),
            .rsp_p_data_o  (p_data[g]),
            .rsp_p_valid_o (p_valid[g]),
            .rsp_q_ready_o (q_ready[g]),
            .sram_req_o    (s_req[g]),
            .sram_gnt_i    (gnt),
            .sram_we_o     (s_we[g]),
            .sram_addr_o   (s_addr[g]),
            .sram_wdata_o  (s_wdata[g]),
            .sram_be_o     (s_be[g]),
            .sram_rdata_i  ((g == 1) ? rd2 : rd1)
`ifdef STITCH_TCDM_RESPONDER_PERF_EN
            ,
            .perf_clr_i    (perf_clr),
            .perf_acc_o    (perf_acc[g]),
            .perf_stall_o  (perf_stall[g])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port bank model: data one cycle after a granted read, one more stage for latency 2.
    always @(posedge clk) begin
        if (s_req[0] && gnt) begin
            if (s_we[0]) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_be[0][b]) mem[s_addr[0]][8*b +: 8] <= s_wdata[0][8*b +: 8];
                end
            end else begin
                rd1 <= mem[s_addr[0]];
            end
        end
        rd2 <= rd1;
    end

    function automatic int tot_lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic g, input logic clr);
        logic        exp_v;
        logic [31:0] rsp;
        int          word;
        q_valid = v; q_write = w; q_addr = a; q_data = d; q_strb = s; gnt = g;
`ifdef STITCH_TCDM_RESPONDER_PERF_EN
        perf_clr = clr;
`endif
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk("q_ready", {31'b0, q_ready[k]}, {31'b0, g});
            chk("sram_req", {31'b0, s_req[k]}, {31'b0, v});
            if (v) begin
                chk("sram_addr", {22'b0, s_addr[k]}, {22'b0, a[11:2]});
                chk("sram_we", {31'b0, s_we[k]}, {31'b0, w});
                chk("sram_wdata", s_wdata[k], d);
                chk("sram_be", {28'b0, s_be[k]}, {28'b0, s});
            end
            exp_v = (exp_q[k].size() > 0) && (exp_q[k][0].due == cyc);
            chk("p_valid", {31'b0, p_valid[k]}, {31'b0, exp_v});
            if (exp_v) begin
                chk("p_data", p_data[k], exp_q[k][0].data);
                if (exp_q[k][0].is_read) last_rd[k] = p_data[k];
                void'(exp_q[k].pop_front());
            end else if (idle_zero) begin
                chk("p_data_idle", p_data[k], 32'h0);
            end
`ifdef STITCH_TCDM_RESPONDER_PERF_EN
            chk("perf_acc", perf_acc[k], m_acc);
            chk("perf_stall", perf_stall[k], m_stall);
`endif
        end
        if (v && g) begin
            word = int'(a[11:2]);
            rsp  = w ? 32'h0 : shadow[word];
            if (w) begin
                for (int b = 0; b < 4; b++) begin
                    if (s[b]) shadow[word][8*b +: 8] = d[8*b +: 8];
                end
            end
            for (int k = 0; k < NDUT; k++) begin
                exp_q[k].push_back('{due: cyc + tot_lat(k), is_read: !w, data: rsp});
            end
        end
`ifdef STITCH_TCDM_RESPONDER_PERF_EN
        if (clr) begin
            m_acc   = 0;
            m_stall = 0;
        end else begin
            if (v && g && m_acc != 32'hFFFF_FFFF) m_acc = m_acc + 1;
            if (v && !g && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) exp_q[k].delete();
`ifdef STITCH_TCDM_RESPONDER_PERF_EN
        m_acc   = 0;
        m_stall = 0;
`endif
    endtask

    initial begin
        logic        hv, hw, hg;
        logic [31:0] ha, hd;
        logic [3:0]  hs;
        n_assert = 0; n_fail = 0; cyc = 0; idle_zero = 1'b1;
        rst_n = 1'b0; q_valid = 0; q_write = 0; q_addr = 0; q_data = 0; q_strb = 0; gnt = 0;
`ifdef STITCH_TCDM_RESPONDER_PERF_EN
        perf_clr = 1'b0;
`endif
        model_reset();
        #1;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        idle_zero = 1'b0;

        // Write then read 0x40.
        step(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 1'b0);
        idle(3);
        for (int k = 0; k < NDUT; k++) chk("rd_deadbeef", last_rd[k], 32'hDEAD_BEEF);

        // Preload words 0..15 (upper address bits scrambled), then back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, ($urandom & 32'hFFFF_F000) | (i << 2), $urandom, 4'hF, 1'b1, 1'b0);
        end
        step(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b1, 1'b0);
        idle(3);

        // Grant stall: three refused cycles, one accept.
        step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 1'b0);
        idle(3);
`ifdef STITCH_TCDM_RESPONDER_PERF_EN
        for (int k = 0; k < NDUT; k++) begin
            chk("perf_stall_3", perf_stall[k], 32'd3);
            chk("perf_acc_1", perf_acc[k], 32'd1);
        end
        step(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 1'b1);
        idle(1);
        for (int k = 0; k < NDUT; k++) chk("perf_clr", perf_acc[k], 32'd0);
`endif

        // Byte enables.
        step(1'b1, 1'b1, 32'h80, 32'h1122_3344, 4'hF, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h80, 32'h0000_AA00, 4'b0010, 1'b1, 1'b0);
        step(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b1, 1'b0);
        idle(3);
        for (int k = 0; k < NDUT; k++) chk("rd_byte_en", last_rd[k], 32'h1122_AA44);

        // Random traffic; a stalled request keeps its payload until granted.
        hv = 0; hw = 0; ha = 0; hd = 0; hs = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(hv && !hg) || i == 0) begin
                hv = ($urandom_range(0, 3) != 0);
                hw = $urandom_range(0, 1);
                ha = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
                hd = $urandom;
                hs = $urandom_range(0, 15);
            end
            hg = ($urandom_range(0, 3) != 0);
            step(hv, hw, ha, hd, hs, hg, ($urandom_range(0, 31) == 0));
        end
        idle(3);

        // Reset with a read in flight.
        step(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, 1'b0);
        rst_n = 1'b0;
        model_reset();
        idle_zero = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(4);
        idle_zero = 1'b0;

        step(1'b1, 1'b0, 32'h80, 32'h0, 4'hF, 1'b1, 1'b0);
        idle(3);
        for (int k = 0; k < NDUT; k++) begin
            chk("rd_after_rst", last_rd[k], 32'h1122_AA44);
            chk("drain", exp_q[k].size(), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
